// File: rtl/brick_field_renderer_pkg.sv
// Shared constants, colour codes and FSM state encoding for the brick-wall renderer.
package brick_field_renderer_pkg;

  localparam int unsigned HVisible = 640;
  localparam int unsigned VVisible = 480;

  localparam logic [2:0] RgbBlack  = 3'b000;
  localparam logic [2:0] RgbRed    = 3'b100;
  localparam logic [2:0] RgbYellow = 3'b110;
  localparam logic [2:0] RgbGreen  = 3'b010;
  localparam logic [2:0] RgbCyan   = 3'b011;
  localparam logic [2:0] RgbWhite  = 3'b111;

  typedef enum logic [1:0] {
    StRun,
    StPendRestore,
    StWon
  } fsm_state_e;

  // Palette repeats every four rows.
  function automatic logic [2:0] row_colour(input logic [2:0] row);
    logic [2:0] rgb;
    unique case (row[1:0])
      2'd0:    rgb = RgbRed;
      2'd1:    rgb = RgbYellow;
      2'd2:    rgb = RgbGreen;
      default: rgb = RgbCyan;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/brick_bitmap_store.sv
// Brick-alive bitmap with read port, single-brick clear, refill-all and running alive count.
module brick_bitmap_store
  import brick_field_renderer_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [2:0] rd_row_i,
  input  logic [3:0] rd_col_i,
  output logic       rd_alive_o,
  input  logic       clr_i,
  input  logic [2:0] clr_row_i,
  input  logic [3:0] clr_col_i,
  input  logic       fill_i,
  output logic [7:0] bricks_left_o
);

  localparam logic [7:0] FullCount = 8'(ROWS * COLS);

  logic [ROWS-1:0][COLS-1:0] bitmap_q, bitmap_d;
  logic [7:0]                count_q, count_d;
  logic                      clr_alive;

  // Out-of-range coordinates match no cell, so they read dead and clear nothing.
  always_comb begin
    bitmap_d   = bitmap_q;
    count_d    = count_q;
    rd_alive_o = 1'b0;
    clr_alive  = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (rd_row_i == 3'(r) && rd_col_i == 4'(c)) begin
          rd_alive_o = bitmap_q[r][c];
        end
        if (clr_row_i == 3'(r) && clr_col_i == 4'(c)) begin
          clr_alive = bitmap_q[r][c];
          if (clr_i) begin
            bitmap_d[r][c] = 1'b0;
          end
        end
      end
    end
    if (fill_i) begin
      bitmap_d = '1;
      count_d  = FullCount;
    end else if (clr_i && clr_alive) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bitmap_q <= '1;
      count_q  <= FullCount;
    end else if (en_i) begin
      bitmap_q <= bitmap_d;
      count_q  <= count_d;
    end
  end

  assign bricks_left_o = count_q;

endmodule

// File: rtl/brick_field_renderer.sv
// Brick-wall pixel layer: 2-stage pixel pipeline plus hit/restore FSM.
// Optional per-row palette enabled by defining BRICK_PALETTE_EN; otherwise every brick is white.
module brick_field_renderer
  import brick_field_renderer_pkg::*;
#(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 8,
  parameter int unsigned BRICK_W   = 80,
  parameter int unsigned BRICK_H   = 24,
  parameter int unsigned GAP       = 2,
  parameter int unsigned FIELD_X0  = 0,
  parameter int unsigned FIELD_Y0  = 64,
  parameter int unsigned V_VISIBLE = VVisible
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [10:0] hpos_i,
  input  logic [10:0] vpos_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        hit_valid_i,
  input  logic [2:0]  hit_row_i,
  input  logic [3:0]  hit_col_i,
  output logic        hit_ready_o,
  input  logic        restore_i,
  output logic        pix_on_o,
  output logic [2:0]  pix_rgb_o,
  output logic        hsync_d_o,
  output logic        vsync_d_o,
  output logic [7:0]  bricks_left_o,
  output logic        all_cleared_o
);

  fsm_state_e state_q;
  logic       hit_pend_q;
  logic [2:0] hit_row_q;
  logic [3:0] hit_col_q;

  logic       in_field_q, in_field_d;
  logic       gap_q, gap_d;
  logic [2:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic       hsync_s1_q, vsync_s1_q;
  logic       pix_on_q, pix_on_d;
  logic [2:0] pix_rgb_q, pix_rgb_d, brick_rgb;
  logic       hsync_q, vsync_q;

  logic [31:0] dx, dy;
  logic        blank, hit_accept, fill, brick_alive;
  logic [7:0]  bricks_left;

  // Positions left of / above the field wrap to huge values and fail the extent test.
  always_comb begin
    dx         = 32'(hpos_i) - FIELD_X0;
    dy         = 32'(vpos_i) - FIELD_Y0;
    in_field_d = (dx < COLS * BRICK_W) && (dy < ROWS * BRICK_H);
    col_d      = 4'(dx / BRICK_W);
    row_d      = 3'(dy / BRICK_H);
    gap_d      = ((dx % BRICK_W) >= BRICK_W - GAP) || ((dy % BRICK_H) >= BRICK_H - GAP);
  end

  always_comb begin
    pix_on_d = in_field_q && !gap_q && brick_alive;
`ifdef BRICK_PALETTE_EN
    brick_rgb = row_colour(row_q);
`else
    brick_rgb = RgbWhite;
`endif
    pix_rgb_d = pix_on_d ? brick_rgb : RgbBlack;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_field_q <= 1'b0;
      gap_q      <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      hsync_s1_q <= 1'b0;
      vsync_s1_q <= 1'b0;
      pix_on_q   <= 1'b0;
      pix_rgb_q  <= RgbBlack;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
    end else if (enable_i) begin
      in_field_q <= in_field_d;
      gap_q      <= gap_d;
      row_q      <= row_d;
      col_q      <= col_d;
      hsync_s1_q <= hsync_i;
      vsync_s1_q <= vsync_i;
      pix_on_q   <= pix_on_d;
      pix_rgb_q  <= pix_rgb_d;
      hsync_q    <= hsync_s1_q;
      vsync_q    <= vsync_s1_q;
    end
  end

  // Bitmap only changes during vertical blanking; restore takes priority over a hit.
  assign blank       = 32'(vpos_i) >= V_VISIBLE;
  assign hit_ready_o = (state_q == StRun) && blank && enable_i && !restore_i &&
                       (bricks_left != 8'd0);
  assign hit_accept  = hit_valid_i && hit_ready_o;
  assign fill        = (state_q == StPendRestore) && blank;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      hit_pend_q <= 1'b0;
      hit_row_q  <= '0;
      hit_col_q  <= '0;
    end else if (enable_i) begin
      hit_pend_q <= hit_accept;
      if (hit_accept) begin
        hit_row_q <= hit_row_i;
        hit_col_q <= hit_col_i;
      end
      unique case (state_q)
        StRun: begin
          if (restore_i) begin
            state_q <= StPendRestore;
          end else if (bricks_left == 8'd0) begin
            state_q <= StWon;
          end
        end
        StPendRestore: begin
          if (blank) begin
            state_q <= StRun;
          end
        end
        StWon: begin
          if (restore_i) begin
            state_q <= StPendRestore;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  brick_bitmap_store #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_store (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (enable_i),
    .rd_row_i      (row_q),
    .rd_col_i      (col_q),
    .rd_alive_o    (brick_alive),
    .clr_i         (hit_pend_q),
    .clr_row_i     (hit_row_q),
    .clr_col_i     (hit_col_q),
    .fill_i        (fill),
    .bricks_left_o (bricks_left)
  );

  assign pix_on_o      = pix_on_q;
  assign pix_rgb_o     = pix_rgb_q;
  assign hsync_d_o     = hsync_q;
  assign vsync_d_o     = vsync_q;
  assign bricks_left_o = bricks_left;
  assign all_cleared_o = (bricks_left == 8'd0);

endmodule

// File: tb/tb_brick_field_renderer.sv
// Self-checking bench for brick_field_renderer: pixel vector table through a scoreboard
// queue, plus hand sequences for hits, clear-all, restore, enable freeze and mid-line reset.
module tb_brick_field_renderer;

`ifdef BRICK_PALETTE_EN
  localparam logic [2:0] C0 = 3'b100;
  localparam logic [2:0] C1 = 3'b110;
  localparam logic [2:0] C2 = 3'b010;
  localparam logic [2:0] C3 = 3'b011;
`else
  localparam logic [2:0] C0 = 3'b111;
  localparam logic [2:0] C1 = 3'b111;
  localparam logic [2:0] C2 = 3'b111;
  localparam logic [2:0] C3 = 3'b111;
`endif

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        on;
    logic [2:0]  rgb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, enable, hsync, vsync, hit_valid, restore;
  logic [10:0] hpos, vpos;
  logic [2:0]  hit_row;
  logic [3:0]  hit_col;
  logic        hit_ready, pix_on, hsync_d, vsync_d, all_cleared;
  logic [2:0]  pix_rgb;
  logic [7:0]  bricks_left;

  int n_checks = 0;
  int n_fail   = 0;
  int model_left;
  bit alive[4][8];

  vec_t stim_q[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  brick_field_renderer u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .hpos_i        (hpos),
    .vpos_i        (vpos),
    .hsync_i       (hsync),
    .vsync_i       (vsync),
    .hit_valid_i   (hit_valid),
    .hit_row_i     (hit_row),
    .hit_col_i     (hit_col),
    .hit_ready_o   (hit_ready),
    .restore_i     (restore),
    .pix_on_o      (pix_on),
    .pix_rgb_o     (pix_rgb),
    .hsync_d_o     (hsync_d),
    .vsync_d_o     (vsync_d),
    .bricks_left_o (bricks_left),
    .all_cleared_o (all_cleared)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int h, input int v, input bit hs, input bit vs,
                              input bit on, input logic [2:0] rgb);
    vec_t r;
    r.h = 11'(h); r.v = 11'(v); r.hs = hs; r.vs = vs; r.on = on; r.rgb = rgb;
    return r;
  endfunction

  task automatic compare_pix();
    vec_t e;
    e = exp_q.pop_front();
    check($sformatf("pix_on(%0d,%0d)", e.h, e.v), pix_on, e.on);
    check($sformatf("pix_rgb(%0d,%0d)", e.h, e.v), pix_rgb, e.rgb);
    check($sformatf("hsync_d(%0d,%0d)", e.h, e.v), hsync_d, e.hs);
    check($sformatf("vsync_d(%0d,%0d)", e.h, e.v), vsync_d, e.vs);
  endtask

  // Stream queued stimulus one pixel per clock; results emerge two clocks after drive.
  task automatic flush();
    vec_t s;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      hpos = s.h; vpos = s.v; hsync = s.hs; vsync = s.vs;
      exp_q.push_back(s);
      @(posedge clk); #1;
      if (exp_q.size() > 1) compare_pix();
    end
    @(posedge clk); #1;
    compare_pix();
  endtask

  task automatic do_hit(input int r, input int c, input bit exp_ready);
    hit_row = 3'(r); hit_col = 4'(c); hit_valid = 1'b1;
    #1;
    check($sformatf("hit_ready(%0d,%0d)", r, c), hit_ready, exp_ready);
    @(posedge clk); #1;
    hit_valid = 1'b0;
    if (exp_ready && r < 4 && c < 8 && alive[r][c]) begin
      alive[r][c] = 1'b0;
      model_left--;
    end
    @(posedge clk); #1;
    check($sformatf("bricks_left after hit(%0d,%0d)", r, c), bricks_left, model_left);
  endtask

  task automatic model_refill();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) alive[r][c] = 1'b1;
    model_left = 32;
  endtask

  initial begin
    vec_t vecs[$];
    rst = 1'b1; enable = 1'b1; hsync = 1'b0; vsync = 1'b0; hit_valid = 1'b0;
    restore = 1'b0; hpos = '0; vpos = '0; hit_row = '0; hit_col = '0;
    model_refill();
    repeat (2) @(posedge clk);
    #1;
    check("reset pix_on", pix_on, 0);
    check("reset pix_rgb", pix_rgb, 0);
    check("reset hsync_d", hsync_d, 0);
    check("reset vsync_d", vsync_d, 0);
    check("reset bricks_left", bricks_left, 32);
    check("reset all_cleared", all_cleared, 0);
    check("reset hit_ready", hit_ready, 0);
    rst = 1'b0;

    vecs = '{mk(10, 70, 1, 0, 1, C0),  mk(79, 70, 0, 1, 0, 0),   mk(78, 70, 1, 1, 0, 0),
             mk(77, 70, 0, 0, 1, C0),  mk(10, 40, 1, 0, 0, 0),   mk(10, 63, 0, 1, 0, 0),
             mk(10, 64, 1, 1, 1, C0),  mk(10, 85, 0, 0, 1, C0),  mk(10, 86, 1, 0, 0, 0),
             mk(10, 88, 0, 1, 1, C1),  mk(10, 117, 1, 1, 1, C2), mk(10, 141, 0, 0, 1, C3),
             mk(10, 155, 1, 0, 1, C3), mk(10, 159, 0, 1, 0, 0),  mk(10, 160, 1, 1, 0, 0),
             mk(630, 70, 0, 0, 1, C0), mk(639, 70, 1, 0, 0, 0),  mk(640, 70, 0, 1, 0, 0),
             mk(250, 95, 1, 1, 1, C1), mk(400, 200, 0, 0, 0, 0)};
    for (int i = 0; i < vecs.size(); i++) stim_q.push_back(vecs[i]);
    flush();

    // Single hit, then render the gap it leaves.
    hpos = '0; vpos = 11'd490;
    do_hit(1, 3, 1);
    stim_q.push_back(mk(250, 95, 0, 0, 0, 0));
    stim_q.push_back(mk(330, 95, 1, 0, 1, C1));
    stim_q.push_back(mk(170, 95, 0, 1, 1, C1));
    flush();

    // Dead and out-of-range hits are accepted but change nothing; visible area refuses hits.
    vpos = 11'd490;
    do_hit(1, 3, 1);
    do_hit(5, 2, 1);
    do_hit(2, 9, 1);
    vpos = 11'd100;
    do_hit(0, 0, 0);

    // Clear the whole wall.
    vpos = 11'd490;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) if (alive[r][c]) do_hit(r, c, 1);
    check("all_cleared after last hit", all_cleared, 1);
    check("hit_ready after last hit", hit_ready, 0);
    do_hit(0, 0, 0);

    // Restore requested mid-frame takes effect on the first blanking line.
    vpos = 11'd200; restore = 1'b1;
    @(posedge clk); #1;
    restore = 1'b0;
    for (int v = 201; v < 480; v++) begin
      vpos = 11'(v);
      restore = (v == 300);
      @(posedge clk); #1;
    end
    restore = 1'b0;
    check("bricks_left before blank", bricks_left, 0);
    check("all_cleared before blank", all_cleared, 1);
    vpos = 11'd480;
    #1;
    check("hit_ready while restore pending", hit_ready, 0);
    @(posedge clk); #1;
    model_refill();
    check("bricks_left after refill", bricks_left, 32);
    check("all_cleared after refill", all_cleared, 0);
    check("hit_ready after refill", hit_ready, 1);

    // Hit and restore in the same cycle: restore wins.
    do_hit(0, 0, 1);
    hit_row = 3'd0; hit_col = 4'd1; hit_valid = 1'b1; restore = 1'b1;
    #1;
    check("hit_ready with restore", hit_ready, 0);
    @(posedge clk); #1;
    hit_valid = 1'b0; restore = 1'b0;
    @(posedge clk); #1;
    model_refill();
    check("bricks_left after hit+restore", bricks_left, 32);
    stim_q.push_back(mk(10, 70, 1, 1, 1, C0));
    stim_q.push_back(mk(90, 70, 0, 0, 1, C0));
    flush();

    // Enable low freezes everything.
    hpos = 11'd10; vpos = 11'd70; hsync = 1'b1; vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre-freeze pix_on", pix_on, 1);
    enable = 1'b0;
    hpos = 11'd79; vpos = 11'd490; hsync = 1'b0; vsync = 1'b1;
    hit_row = 3'd0; hit_col = 4'd0; hit_valid = 1'b1;
    #1;
    check("hit_ready while disabled", hit_ready, 0);
    repeat (10) @(posedge clk);
    #1;
    check("frozen pix_on", pix_on, 1);
    check("frozen pix_rgb", pix_rgb, C0);
    check("frozen hsync_d", hsync_d, 1);
    check("frozen vsync_d", vsync_d, 0);
    check("frozen bricks_left", bricks_left, 32);
    hit_valid = 1'b0; enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("thawed pix_on", pix_on, 0);
    check("thawed hsync_d", hsync_d, 0);
    check("thawed vsync_d", vsync_d, 1);

    // Mid-line reset discards a pending hit and restores reset values at once.
    vpos = 11'd490;
    do_hit(2, 2, 1);
    hpos = 11'd10; vpos = 11'd70; hsync = 1'b1; vsync = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vpos = 11'd490; hit_row = 3'd0; hit_col = 4'd0; hit_valid = 1'b1;
    #1;
    check("hit_ready before reset", hit_ready, 1);
    @(posedge clk); #1;
    hit_valid = 1'b0; vpos = 11'd100;
    check("pix_on before reset", pix_on, 1);
    #2 rst = 1'b1;
    #1;
    check("mid reset pix_on", pix_on, 0);
    check("mid reset pix_rgb", pix_rgb, 0);
    check("mid reset hsync_d", hsync_d, 0);
    check("mid reset vsync_d", vsync_d, 0);
    check("mid reset bricks_left", bricks_left, 32);
    check("mid reset all_cleared", all_cleared, 0);
    check("mid reset hit_ready", hit_ready, 0);
    #10 rst = 1'b0;
    model_refill();
    stim_q.push_back(mk(10, 70, 0, 1, 1, C0));
    stim_q.push_back(mk(170, 118, 1, 0, 1, C2));
    flush();
    check("bricks_left after reset", bricks_left, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
